// File: rtl/ball_tick_gen.sv
// Ball move-tick generator: turns a clamped speed select N into a one-cycle
// move_tick every 2^(N+1) clocks, with pause, tick counting and tick-aligned speed changes.
module ball_tick_gen #(
    parameter int MIN_SEL   = 17,
    parameter int MAX_SEL   = 19,
    parameter int RESET_SEL = 19,
    parameter int TCNT_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [5:0]        speed,
    input  logic              pause,
    input  logic              tick_clr,
    output logic              move_tick,
    output logic [5:0]        active_sel,
    output logic [TCNT_W-1:0] tick_count
);

    localparam int CNT_W = MAX_SEL + 1;

    localparam logic [5:0] MIN_S   = 6'(MIN_SEL);
    localparam logic [5:0] MAX_S   = 6'(MAX_SEL);
    localparam logic [5:0] RESET_S = 6'(RESET_SEL);

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              tick_q, tick_d;
    logic [5:0]        sel_q, sel_d;
    logic [TCNT_W-1:0] tcnt_q, tcnt_d;
    logic [CNT_W-1:0]  term;

    function automatic logic [5:0] clamp_sel(input logic [5:0] x);
        if (x < MIN_S)
            return MIN_S;
        else if (x > MAX_S)
            return MAX_S;
        else
            return x;
    endfunction

    // Terminal count 2^(sel+1)-1 is simply the low sel+1 bits set.
    function automatic logic [CNT_W-1:0] term_of(input logic [5:0] sel);
        logic [CNT_W-1:0] t;
        for (int i = 0; i < CNT_W; i++)
            t[i] = (i <= int'(sel));
        return t;
    endfunction

    assign term = term_of(sel_q);

    always_comb begin
        cnt_d  = cnt_q;
        tick_d = 1'b0;
        sel_d  = sel_q;
        tcnt_d = tcnt_q;
        if (!pause) begin
            if (cnt_q == term) begin
                cnt_d  = '0;
                tick_d = 1'b1;
                sel_d  = clamp_sel(speed);
                tcnt_d = tcnt_q + 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        if (tick_clr)
            tcnt_d = '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
            sel_q  <= RESET_S;
            tcnt_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
            sel_q  <= sel_d;
            tcnt_q <= tcnt_d;
        end
    end

    assign move_tick  = tick_q;
    assign active_sel = sel_q;
    assign tick_count = tcnt_q;

endmodule

// File: tb/tb_ball_tick_gen.sv
// Bench for ball_tick_gen with a small select range; a behavioural model feeds a
// scoreboard queue each cycle, plus directed checks on tick spacing and counter values.
module tb_ball_tick_gen;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] speed;
    logic       pause;
    logic       tick_clr;
    logic       move_tick;
    logic [5:0] active_sel;
    logic [3:0] tick_count;

    always #5 clk = ~clk;

    ball_tick_gen #(
        .MIN_SEL  (1),
        .MAX_SEL  (4),
        .RESET_SEL(2),
        .TCNT_W   (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .speed     (speed),
        .pause     (pause),
        .tick_clr  (tick_clr),
        .move_tick (move_tick),
        .active_sel(active_sel),
        .tick_count(tick_count)
    );

    typedef struct {
        int tick;
        int sel;
        int tc;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_pass = 0;
    int   n_tk = 0;

    // Reference model: elapsed cycles in the current period and the governing select.
    int m_el  = 0;
    int m_sel = 2;
    int m_tc  = 0;
    int m_tick = 0;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    endtask

    function automatic int clamp_ref(input int x);
        if (x < 1) return 1;
        if (x > 4) return 4;
        return x;
    endfunction

    task automatic model_step();
        exp_t e;
        if (reset) begin
            m_el = 0; m_tick = 0; m_sel = 2; m_tc = 0;
        end else begin
            m_tick = 0;
            if (!pause) begin
                if (m_el + 1 == (1 << (m_sel + 1))) begin
                    m_el   = 0;
                    m_tick = 1;
                    m_sel  = clamp_ref(int'(speed));
                    m_tc   = (m_tc + 1) % 16;
                end else begin
                    m_el++;
                end
            end
            if (tick_clr) m_tc = 0;
        end
        e.tick = m_tick; e.sel = m_sel; e.tc = m_tc;
        sb.push_back(e);
    endtask

    task automatic cycle();
        exp_t e;
        model_step();
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check_val("sb_tick", int'(move_tick), e.tick);
        check_val("sb_sel", int'(active_sel), e.sel);
        check_val("sb_tc", int'(tick_count), e.tc);
        if (move_tick) n_tk++;
    endtask

    task automatic wait_tick(input int maxc, output int n);
        n = 0;
        do begin
            cycle();
            n++;
        end while (!move_tick && n < maxc);
        if (!move_tick) check_val("tick_timeout", 0, 1);
    endtask

    int n;
    int tk0;

    initial begin
        reset = 1'b1; speed = 6'd2; pause = 1'b0; tick_clr = 1'b0;
        cycle();
        cycle();
        check_val("rst_tick", int'(move_tick), 0);
        check_val("rst_sel", int'(active_sel), 2);
        check_val("rst_tc", int'(tick_count), 0);

        // First ticks after release: every 8 cycles, count 1..3.
        reset = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            wait_tick(64, n);
            check_val("period8", n, 8);
            check_val("tc_run", int'(tick_count), i);
        end
        cycle();
        check_val("one_cycle_pulse", int'(move_tick), 0);

        // Speed change mid-period waits for the terminal edge.
        cycle();
        speed = 6'd1;
        wait_tick(64, n);
        check_val("old_period_kept", n, 6);
        check_val("sel_to_1", int'(active_sel), 1);
        wait_tick(64, n);
        check_val("period4", n, 4);

        // Clamping at both ends.
        speed = 6'd0;
        wait_tick(64, n);
        check_val("period4_b", n, 4);
        check_val("clamp_low", int'(active_sel), 1);
        speed = 6'd63;
        wait_tick(64, n);
        check_val("period4_c", n, 4);
        check_val("clamp_high", int'(active_sel), 4);
        wait_tick(64, n);
        check_val("period32", n, 32);
        speed = 6'd2;
        wait_tick(64, n);
        check_val("period32_b", n, 32);
        check_val("sel_back_2", int'(active_sel), 2);
        wait_tick(64, n);
        check_val("period8_b", n, 8);

        // Pause held 5 cycles starting at cnt==term stretches the period to 13.
        for (int i = 0; i < 7; i++) cycle();
        tk0 = n_tk;
        pause = 1'b1;
        for (int i = 0; i < 5; i++) cycle();
        check_val("no_tick_in_pause", n_tk - tk0, 0);
        pause = 1'b0;
        wait_tick(64, n);
        check_val("tick_after_pause", n, 1);

        // Reset mid-period at cnt=5 with tick_count=3.
        tick_clr = 1'b1;
        cycle();
        tick_clr = 1'b0;
        check_val("clr_plain", int'(tick_count), 0);
        for (int i = 0; i < 3; i++) wait_tick(64, n);
        check_val("tc_before_rst", int'(tick_count), 3);
        for (int i = 0; i < 5; i++) cycle();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        check_val("midrst_tick", int'(move_tick), 0);
        check_val("midrst_sel", int'(active_sel), 2);
        check_val("midrst_tc", int'(tick_count), 0);
        wait_tick(64, n);
        check_val("midrst_period", n, 8);

        // Clear on the same edge as a tick: clear wins, pulse still fires.
        for (int i = 0; i < 7; i++) cycle();
        tick_clr = 1'b1;
        cycle();
        tick_clr = 1'b0;
        check_val("clr_tick_pulse", int'(move_tick), 1);
        check_val("clr_wins", int'(tick_count), 0);

        // 16 ticks wrap the 4-bit counter.
        speed = 6'd1;
        for (int i = 0; i < 16; i++) begin
            wait_tick(64, n);
            if (i == 14) check_val("tc_15", int'(tick_count), 15);
            if (i == 15) check_val("tc_wrap", int'(tick_count), 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/ball_tick_gen.md
Name: ball_tick_gen

Overview:
- Consumes the 6-bit speed select produced by the difficulty block and turns it into the periodic one-cycle enable that advances the ball.
- Select value N gives a move period of 2^(N+1) clk cycles.
- A speed change takes effect only at a tick boundary, so the period in progress is never shortened or glitched.
- Also provides pause and a tick counter for the game FSM and the score/debug logic.

Parameters:
- MIN_SEL, 17, smallest accepted select; lower requests are clamped up to this value.
- MAX_SEL, 19, largest accepted select; higher requests are clamped down to this value. Internal period counter width is MAX_SEL+1 bits.
- RESET_SEL, 19, select loaded on reset; must lie in [MIN_SEL, MAX_SEL].
- TCNT_W, 16, width of tick_count.

Ports:
- clk, input, 1, system clock; the single clock of the block.
- reset, input, 1, synchronous, active-high reset.
- speed, input, 6, requested select from the difficulty block; sampled only at tick boundaries.
- pause, input, 1, freezes the period counter and suppresses ticks while high.
- tick_clr, input, 1, synchronous clear of tick_count.
- move_tick, output, 1, registered one-cycle pulse that moves the ball one step.
- active_sel, output, 6, select currently governing the period (post-clamp).
- tick_count, output, TCNT_W, number of move_ticks issued; wraps modulo 2^TCNT_W.

Behaviour:
- Reset (sampled at posedge clk with reset=1): cnt=0, move_tick=0, active_sel=RESET_SEL, tick_count=0. Reset has priority over every other input. A reset applied mid-period discards the partial period; the next full period starts from cnt=0.
- Terminal value: term = 2^(active_sel+1) - 1.
- Each posedge with reset=0, evaluated in this priority order:
  - pause=1: cnt holds, move_tick<=0, active_sel holds.
  - else cnt==term: cnt<=0, move_tick<=1, active_sel<=clamp(speed).
  - else: cnt<=cnt+1, move_tick<=0.
- clamp(x): returns MIN_SEL if x<MIN_SEL, MAX_SEL if x>MAX_SEL, otherwise x.
- Timing:
  - move_tick is high for exactly one cycle.
  - With no pause, consecutive ticks are exactly 2^(active_sel+1) cycles apart.
  - First tick after reset release: move_tick is high in the cycle following the 2^(RESET_SEL+1)-th rising edge with reset=0.
- Speed changes between ticks are ignored until the next terminal edge. The value of speed sampled at that edge sets the period that starts then. The new active_sel is visible in the same cycle as move_tick.
- Pause:
  - Pause asserted with cnt==term suppresses the tick.
  - The tick fires on the first non-paused edge after pause drops.
  - Total elapsed time is stretched by exactly the number of paused cycles.
- tick_count:
  - Increments on every edge that sets move_tick<=1.
  - tick_clr=1 forces it to 0, and clear wins over a simultaneous increment.
  - Wraps from 2^TCNT_W-1 to 0 with no flag.
- No combinational path from any input to any output.

Test Plan:
- Bench overrides MIN_SEL=1, MAX_SEL=4, RESET_SEL=2 so simulations stay short.
- Reset, then release with speed=2, pause=0 -> active_sel=2; move_tick is high after release edge 8, then every 8 cycles; tick_count reads 1, 2, 3.
- speed changed from 2 to 1 two cycles after a tick -> the current period still runs 8 cycles; at its terminal edge active_sel=1, and subsequent ticks are 4 cycles apart.
- speed=0 latched -> active_sel=1 (clamped up); speed=63 latched -> active_sel=4, tick period 32 cycles.
- pause held for 5 cycles starting at cnt==term -> no tick during pause; tick on the first edge after pause falls; that period is 13 cycles instead of 8.
- reset asserted mid-period at cnt=5 with tick_count=3 -> next cycle cnt=0, tick_count=0, active_sel=2, move_tick=0; first new tick 8 cycles after release.
- tick_clr asserted on the same edge as a tick -> tick_count=0 and move_tick=1. Separately, with TCNT_W=4, 16 ticks -> tick_count wraps to 0.
